tetris_piece_bag: RTL and testbench
===================================

# tetris_piece_bag

Upstream piece source for the Tetris game core: it produces the next falling piece as an `active_piece_t` spawn record using the standard 7-bag randomizer. Every run of 7 consecutive pieces is a permutation of `PIECE_I..PIECE_Z`. A 2-entry queue holds the next piece and a one-piece preview for the display. The game core pulls pieces with a valid/ready handshake.

## Interface
- `SEED`, default `16'hACE1`: LFSR reset value. A value of 0 is replaced by `16'h0001`.
- `SPAWN_X`, default `4`: x field of the spawn record.
- `SPAWN_Y`, default `0`: y field of the spawn record.

Ports:
- `clk`  in  1: game clock.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `piece_ready`  in  1: the game core accepts `spawn_piece` this cycle.
- `reseed`  in  1: single-cycle pulse that loads `seed_in` into the LFSR.
- `seed_in`  in  16: new LFSR value. A value of 0 is replaced by `16'h0001`.
- `piece_valid`  out  1: `spawn_piece` is valid.
- `spawn_piece`  out  14 (`active_piece_t`): `{Q0, ROT_0, SPAWN_X, SPAWN_Y}`.
- `preview_piece`  out  3 (`piece_type_t`): Q1, the piece after the next one.
- `bag_remaining`  out  3: popcount of the bag mask, range 1..7.

## Operation
State held:
- 16-bit Galois LFSR: shift right; if the old lsb is 1, XOR with `16'hB400`.
- 7-bit bag mask. Bit n means piece n (enum order) is still available.
- Queue registers Q0 and Q1.
- FSM: `FILL0 -> FILL1 -> READY`.

LFSR:
- Advances on every clock edge in every state.
- `reseed` has priority over advancing. On a `reseed` edge the LFSR loads the sanitized `seed_in`.

Draw (combinational, single cycle):
- Candidate `c = lfsr[2:0]`. If `c == 7`, use `c = 0`.
- The drawn piece is the first set mask bit at index c, c+1, … 6, 0, … (wrapping scan).
- `mask_next = mask & ~onehot(drawn)`. If `mask_next == 0`, load `7'h7F` instead, so the bag refills on the same edge.
- Draws always use the LFSR value before the edge's update.

FSM:
- `FILL0`: draw into Q0, go to `FILL1`.
- `FILL1`: draw into Q1, go to `READY`, set `piece_valid`.
- `READY`: on `piece_valid & piece_ready`, Q0 takes Q1, Q1 takes a new draw, and the mask updates. Otherwise the queue and mask hold.
- `piece_ready` is ignored outside `READY`.

Rules:
- No other transitions. `READY` is terminal until reset.
- `reset_n` low at any time, including mid-handshake, clears everything asynchronously. The FILL sequence restarts on release.
- `reseed` does not touch the mask or queue.

## Timing
Reset values of all outputs:
- `piece_valid = 0`
- `spawn_piece = {PIECE_I, ROT_0, SPAWN_X, SPAWN_Y}` (HERO at default spawn)
- `preview_piece = PIECE_I`
- `bag_remaining = 7`
- Internal state: LFSR = sanitized `SEED`, mask = `7'h7F`, FSM = `FILL0`.

Fill latency: `piece_valid` rises after the 2nd rising edge following `reset_n` release and stays high until the next reset.

Handshake:
- Transfer occurs at the edge where `piece_valid & piece_ready` are both high.
- The new Q0, Q1 and `bag_remaining` are visible the next cycle.
- Back-to-back transfers every cycle are supported; throughput is 1 piece per clock.
- `piece_ready` held high with no transfer pending is harmless.

All outputs are registered except `spawn_piece`, which is a pure repacking of Q0 with constants.

## Test plan
1. **Reset and fill:** `SEED=16'h0001`, release `reset_n`, `piece_ready=0`. Required:
   - Edge 1 draws `c=1`, so Q0 = `PIECE_O`; LFSR becomes `B400`.
   - Edge 2 draws `c=0`, so Q1 = `PIECE_I`; LFSR becomes `5A00`.
   - Then `piece_valid=1`, spawn = `{O, ROT_0, 4, 0}`, preview = I, `bag_remaining=5`.
2. **First transfer with wrapping scan:** same setup, `piece_ready` held high from release. Required:
   - At edge 3, `c=0` but I is already taken, so the scan selects `PIECE_T`.
   - Next cycle: spawn = I, preview = T, `bag_remaining=4`.
3. **Bag permutation:** `piece_ready` held high for 70 transfers, with any `SEED`. Required:
   - Each aligned group of 7 accepted pieces (after the fill) contains each of the 7 types exactly once.
   - `bag_remaining` never reads 0.
   - The count runs 5,4,3,2,1,7,6,… with the jump to 7 appearing right after the bag-emptying draw.
4. **Stall:** `piece_ready=0` for 20 cycles in `READY`. Required: spawn, preview and `bag_remaining` are unchanged while the LFSR keeps advancing.
5. **Reseed:** `reseed=1` with `seed_in=0` on the same edge as a transfer. Required:
   - The draw uses the old LFSR value.
   - The LFSR becomes `0001`.
   - `bag_remaining` decrements normally.
6. **Mid-operation reset:** assert `reset_n=0` asynchronously in the middle of a cycle while in `READY` with `piece_ready=1`. Required:
   - Outputs immediately take their reset values.
   - After release, the test 1 sequence repeats exactly.

Source files
------------

// File: rtl/tetris_piece_bag.sv
// 7-bag piece randomizer: keeps a 16-bit Galois LFSR, a bag mask, and a
// two-entry queue (next piece and preview). The game core pulls pieces
// with a valid/ready handshake.
module tetris_piece_bag #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned SPAWN_X = 4,
  parameter int unsigned SPAWN_Y = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        piece_ready,
  input  logic        reseed,
  input  logic [15:0] seed_in,
  output logic        piece_valid,
  output logic [13:0] spawn_piece,
  output logic [2:0]  preview_piece,
  output logic [2:0]  bag_remaining
);

  localparam logic [1:0] FILL0 = 2'd0;
  localparam logic [1:0] FILL1 = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  localparam logic [2:0]  PIECE_I = 3'd0;
  localparam logic [1:0]  ROT_0   = 2'd0;
  localparam logic [15:0] POLY    = 16'hB400;
  localparam logic [15:0] SEED_S  = (SEED == '0) ? 16'h0001 : SEED;
  localparam logic [3:0]  SX      = 4'(SPAWN_X);
  localparam logic [4:0]  SY      = 5'(SPAWN_Y);

  logic [15:0] lfsr_q, lfsr_d;
  logic [6:0]  mask_q, mask_d;
  logic [2:0]  q0_q, q0_d;
  logic [2:0]  q1_q, q1_d;
  logic [2:0]  bag_q, bag_d;
  logic        valid_q, valid_d;
  logic [1:0]  state_q, state_d;

  logic [2:0]  cand;
  logic [2:0]  drawn;
  logic        found;
  logic [3:0]  sum;
  logic [6:0]  mask_left;
  logic [6:0]  mask_after;
  logic [2:0]  cnt;
  logic        take;

  // LFSR next value: reseed wins over the Galois shift.
  always_comb begin
    if (reseed) begin
      lfsr_d = (seed_in == '0) ? 16'h0001 : seed_in;
    end else begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
    end
  end

  // Draw: wrapping scan from the LFSR candidate for the first available piece.
  always_comb begin
    cand  = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
    drawn = '0;
    found = 1'b0;
    sum   = '0;
    for (int unsigned k = 0; k < 7; k++) begin
      sum = {1'b0, cand} + 4'(k);
      if (sum >= 4'd7) sum = sum - 4'd7;
      if (!found && mask_q[sum[2:0]]) begin
        drawn = sum[2:0];
        found = 1'b1;
      end
    end
    mask_left  = mask_q & ~(7'b1 << drawn);
    // Refill on the same edge that empties the bag so the count never reads 0.
    mask_after = (mask_left == '0) ? 7'h7F : mask_left;
    cnt = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      cnt = cnt + {2'b00, mask_after[i]};
    end
  end

  // Fill sequence and queue shift on handshake.
  always_comb begin
    state_d = state_q;
    q0_d    = q0_q;
    q1_d    = q1_q;
    valid_d = valid_q;
    take    = 1'b0;
    case (state_q)
      FILL0: begin
        q0_d    = drawn;
        take    = 1'b1;
        state_d = FILL1;
      end
      FILL1: begin
        q1_d    = drawn;
        take    = 1'b1;
        valid_d = 1'b1;
        state_d = READY;
      end
      READY: begin
        if (valid_q && piece_ready) begin
          q0_d = q1_q;
          q1_d = drawn;
          take = 1'b1;
        end
      end
      default: state_d = state_q;
    endcase
    mask_d = take ? mask_after : mask_q;
    bag_d  = take ? cnt : bag_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q  <= SEED_S;
      mask_q  <= 7'h7F;
      q0_q    <= PIECE_I;
      q1_q    <= PIECE_I;
      bag_q   <= 3'd7;
      valid_q <= 1'b0;
      state_q <= FILL0;
    end else begin
      lfsr_q  <= lfsr_d;
      mask_q  <= mask_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      bag_q   <= bag_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  assign piece_valid   = valid_q;
  assign spawn_piece   = {q0_q, ROT_0, SX, SY};
  assign preview_piece = q1_q;
  assign bag_remaining = bag_q;

endmodule

// File: tb/tb_tetris_piece_bag.sv
// Self-checking bench for tetris_piece_bag: hand-derived vector table,
// randomized traffic against a bag/queue reference model, stall, bag
// permutation and mid-operation reset sequences.
module tb_tetris_piece_bag;

  logic        clk;
  logic        reset_n;
  logic        piece_ready;
  logic        reseed;
  logic [15:0] seed_in;
  logic        piece_valid;
  logic [13:0] spawn_piece;
  logic [2:0]  preview_piece;
  logic [2:0]  bag_remaining;

  int checks = 0;
  int errors = 0;

  tetris_piece_bag #(.SEED(16'h0001), .SPAWN_X(4), .SPAWN_Y(0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .piece_ready  (piece_ready),
    .reseed       (reseed),
    .seed_in      (seed_in),
    .piece_valid  (piece_valid),
    .spawn_piece  (spawn_piece),
    .preview_piece(preview_piece),
    .bag_remaining(bag_remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: available-piece set, count, queue and LFSR.
  int          m_fill;
  bit          m_valid;
  int          m_q0, m_q1;
  bit          m_avail[7];
  int          m_count;
  int unsigned m_lfsr;
  int          accepted[$];

  function automatic logic [13:0] spawn_of(input int p);
    logic [2:0] t;
    t = 3'(p);
    return {t, 2'b00, 4'd4, 5'd0};
  endfunction

  task automatic model_reset();
    m_fill = 0; m_valid = 0; m_q0 = 0; m_q1 = 0; m_count = 7; m_lfsr = 1;
    for (int i = 0; i < 7; i++) m_avail[i] = 1;
  endtask

  function automatic int model_draw();
    int c;
    int p;
    c = int'(m_lfsr % 8);
    if (c == 7) c = 0;
    for (int k = 0; k < 7; k++) begin
      p = (c + k) % 7;
      if (m_avail[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_take(input int p);
    m_avail[p] = 0;
    m_count = m_count - 1;
    if (m_count == 0) begin
      for (int i = 0; i < 7; i++) m_avail[i] = 1;
      m_count = 7;
    end
  endtask

  task automatic model_step(input bit rdy, input bit rs, input int unsigned sd);
    int p;
    p = model_draw();
    if (m_fill == 0) begin
      m_q0 = p; model_take(p); m_fill = 1;
    end else if (m_fill == 1) begin
      m_q1 = p; model_take(p); m_fill = 2; m_valid = 1;
    end else if (m_valid && rdy) begin
      m_q0 = m_q1; m_q1 = p; model_take(p);
    end
    if (rs) m_lfsr = (sd == 0) ? 1 : sd;
    else    m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2 == 1) ? 32'hB400 : 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_valid"},   32'(piece_valid),   32'(m_valid));
    chk({tag, "_spawn"},   32'(spawn_piece),   32'(spawn_of(m_q0)));
    chk({tag, "_preview"}, 32'(preview_piece), 32'(m_q1));
    chk({tag, "_bag"},     32'(bag_remaining), 32'(m_count));
    chk({tag, "_lfsr"},    32'(dut.lfsr_q),    m_lfsr);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},   32'(piece_valid),   32'd0);
    chk({tag, "_spawn"},   32'(spawn_piece),   32'(spawn_of(0)));
    chk({tag, "_preview"}, 32'(preview_piece), 32'd0);
    chk({tag, "_bag"},     32'(bag_remaining), 32'd7);
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle.
  task automatic step(input bit rdy, input bit rs, input logic [15:0] sd);
    piece_ready = rdy;
    reseed      = rs;
    seed_in     = sd;
    if (piece_valid && rdy) accepted.push_back(int'(spawn_piece[13:11]));
    @(posedge clk);
    model_step(rdy, rs, int'(sd));
    #1;
    reseed = 1'b0;
  endtask

  typedef struct {
    bit          rdy;
    bit          rs;
    logic [15:0] sd;
    bit          ev;
    int          eq0;
    int          eq1;
    int          ebag;
    logic [15:0] elfsr;
  } vec_t;

  vec_t tbl[9];

  task automatic run_table(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(tbl[i].rdy, tbl[i].rs, tbl[i].sd);
      chk($sformatf("%s%0d_valid", tag, i),   32'(piece_valid),   32'(tbl[i].ev));
      chk($sformatf("%s%0d_spawn", tag, i),   32'(spawn_piece),   32'(spawn_of(tbl[i].eq0)));
      chk($sformatf("%s%0d_preview", tag, i), 32'(preview_piece), 32'(tbl[i].eq1));
      chk($sformatf("%s%0d_bag", tag, i),     32'(bag_remaining), 32'(tbl[i].ebag));
      chk($sformatf("%s%0d_lfsr", tag, i),    32'(dut.lfsr_q),    32'(tbl[i].elfsr));
    end
  endtask

  initial begin
    logic [13:0] snap_spawn;
    logic [2:0]  snap_prev;
    logic [2:0]  snap_bag;
    logic [6:0]  seen;
    int          exp_bag;

    // rdy rs seed  valid q0 q1 bag lfsr  (I=0 O=1 T=2)
    tbl[0] = '{0, 0, 16'h0000, 0, 1, 0, 6, 16'hB400};
    tbl[1] = '{0, 0, 16'h0000, 1, 1, 0, 5, 16'h5A00};
    tbl[2] = '{1, 0, 16'h0000, 1, 0, 2, 4, 16'h2D00};
    tbl[3] = '{1, 0, 16'h0000, 1, 2, 3, 3, 16'h1680};
    tbl[4] = '{0, 0, 16'h0000, 1, 2, 3, 3, 16'h0B40};
    tbl[5] = '{1, 1, 16'h0000, 1, 3, 4, 2, 16'h0001};
    tbl[6] = '{1, 0, 16'h0000, 1, 4, 5, 1, 16'hB400};
    tbl[7] = '{1, 0, 16'h0000, 1, 5, 6, 7, 16'h5A00};
    tbl[8] = '{1, 0, 16'h0000, 1, 6, 0, 6, 16'h2D00};

    reset_n = 1'b0; piece_ready = 1'b0; reseed = 1'b0; seed_in = '0;
    model_reset();
    #12;
    chk_reset_outputs("rst");
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'h0001);
    reset_n = 1'b1;

    // Fill, wrapping-scan transfer, hold, reseed on transfer, bag refill.
    run_table(9, "tbl");

    // Randomized traffic against the model, with occasional reseeds.
    for (int i = 0; i < 300; i++) begin
      bit          r;
      bit          s;
      logic [15:0] sd;
      r  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 15) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      step(r, s, sd);
      chk_model("rnd");
    end

    // Stall: queue and count hold while the LFSR keeps moving.
    snap_spawn = spawn_piece; snap_prev = preview_piece; snap_bag = bag_remaining;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 16'h0000);
      if (i % 5 == 4) begin
        chk("stall_spawn",   32'(spawn_piece),   32'(snap_spawn));
        chk("stall_preview", 32'(preview_piece), 32'(snap_prev));
        chk("stall_bag",     32'(bag_remaining), 32'(snap_bag));
        chk("stall_lfsr",    32'(dut.lfsr_q),    m_lfsr);
      end
    end
    step(1'b1, 1'b0, 16'h0000);
    chk_model("after_stall");

    // Mid-cycle asynchronous reset while READY with piece_ready high.
    piece_ready = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    accepted.delete();
    @(posedge clk);
    #1;
    chk_reset_outputs("held_rst");
    chk("held_rst_lfsr", 32'(dut.lfsr_q), 32'h0001);
    reset_n = 1'b1;
    run_table(2, "refill");

    // 70 back-to-back transfers: permutation groups and count sequence.
    for (int i = 1; i <= 70; i++) begin
      step(1'b1, 1'b0, 16'h0000);
      exp_bag = 5 - i;
      while (exp_bag < 1) exp_bag += 7;
      chk("b2b_bag", 32'(bag_remaining), 32'(exp_bag));
      if (i % 10 == 0) chk_model("b2b");
    end
    chk("accepted_count", 32'(accepted.size()), 32'd70);
    for (int g = 0; g < 10; g++) begin
      seen = '0;
      for (int j = 0; j < 7; j++) begin
        if (g * 7 + j < accepted.size()) seen |= 7'b1 << accepted[g * 7 + j];
      end
      chk($sformatf("perm_group%0d", g), 32'(seen), 32'h7F);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
